// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// load/store. One outstanding transaction, round-robin on contention, and a
// WAIT-state response timeout so a hung memory cannot stall the core forever.
module mem_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   // instruction fetch port
   input  logic            i_if_req,
   input  logic [AW-1:0]   i_if_addr,
   output logic            o_if_gnt,
   output logic            o_if_rvalid,
   output logic [DW-1:0]   o_if_rdata,
   output logic            o_if_err,
   // data port
   input  logic            i_d_req,
   input  logic            i_d_we,
   input  logic [AW-1:0]   i_d_addr,
   input  logic [DW-1:0]   i_d_wdata,
   input  logic [DW/8-1:0] i_d_wstrb,
   output logic            o_d_gnt,
   output logic            o_d_rvalid,
   output logic [DW-1:0]   o_d_rdata,
   output logic            o_d_err,
   // memory port
   output logic            o_m_req,
   output logic            o_m_we,
   output logic [AW-1:0]   o_m_addr,
   output logic [DW-1:0]   o_m_wdata,
   output logic [DW/8-1:0] o_m_wstrb,
   input  logic            i_m_gnt,
   input  logic            i_m_rvalid,
   input  logic [DW-1:0]   i_m_rdata,
   // status
   output logic            o_busy
);

   localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit          TO_EN = (TIMEOUT != 0);
   localparam logic        OWN_IF = 1'b0;
   localparam logic        OWN_D  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t          state;
   logic            last_owner;   // owner of the current / most recent transaction
   logic [CW-1:0]   cnt;

   logic            sel_d;
   logic            to_hit;
   logic            rsp_ok;
   logic            rsp_to;
   logic            rsp_fire;

   // Owner selection and response qualification for the current cycle
   always_comb begin
      sel_d    = i_d_req & (~i_if_req | (last_owner == OWN_IF));
      to_hit   = TO_EN && (cnt == CW'(TIMEOUT));
      rsp_ok   = ((state == S_ISSUE) & i_m_gnt & i_m_rvalid) |
                 ((state == S_WAIT) & i_m_rvalid);
      rsp_to   = (state == S_WAIT) & ~i_m_rvalid & to_hit;
      rsp_fire = rsp_ok | rsp_to;
   end

   // Arbiter FSM with registered grant, memory-request and response outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         last_owner  <= OWN_IF;
         cnt         <= '0;
         o_if_gnt    <= 1'b0;
         o_if_rvalid <= 1'b0;
         o_if_rdata  <= '0;
         o_if_err    <= 1'b0;
         o_d_gnt     <= 1'b0;
         o_d_rvalid  <= 1'b0;
         o_d_rdata   <= '0;
         o_d_err     <= 1'b0;
         o_m_req     <= 1'b0;
         o_m_we      <= 1'b0;
         o_m_addr    <= '0;
         o_m_wdata   <= '0;
         o_m_wstrb   <= '0;
         o_busy      <= 1'b0;
      end else begin
         // pulses default low every cycle
         o_if_gnt    <= 1'b0;
         o_d_gnt     <= 1'b0;
         o_if_rvalid <= 1'b0;
         o_d_rvalid  <= 1'b0;
         o_if_err    <= 1'b0;
         o_d_err     <= 1'b0;

         // deliver a response to whoever owns the transaction
         if (rsp_fire) begin
            if (last_owner == OWN_D) begin
               o_d_rvalid <= 1'b1;
               o_d_err    <= rsp_to;
               if (!rsp_to && !o_m_we) begin
                  o_d_rdata <= i_m_rdata;
               end
            end else begin
               o_if_rvalid <= 1'b1;
               o_if_err    <= rsp_to;
               if (!rsp_to) begin
                  o_if_rdata <= i_m_rdata;
               end
            end
         end

         case (state)
            S_IDLE: begin
               if (i_if_req || i_d_req) begin
                  last_owner <= sel_d;
                  o_m_req    <= 1'b1;
                  o_busy     <= 1'b1;
                  state      <= S_ISSUE;
                  if (sel_d) begin
                     o_d_gnt   <= 1'b1;
                     o_m_we    <= i_d_we;
                     o_m_addr  <= i_d_addr;
                     o_m_wdata <= i_d_wdata;
                     o_m_wstrb <= i_d_wstrb;
                  end else begin
                     o_if_gnt  <= 1'b1;
                     o_m_we    <= 1'b0;
                     o_m_addr  <= i_if_addr;
                     o_m_wdata <= '0;
                     o_m_wstrb <= '0;
                  end
               end
            end

            S_ISSUE: begin
               // no timeout here: memory may stall the grant indefinitely
               if (i_m_gnt) begin
                  o_m_req <= 1'b0;
                  cnt     <= '0;
                  if (i_m_rvalid) begin
                     state  <= S_IDLE;
                     o_busy <= 1'b0;
                  end else begin
                     state  <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (i_m_rvalid || to_hit) begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            default: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, write, timeout, grant stall,
// mid-transaction reset and round-robin contention.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 4;

   logic            clk;
   logic            rst_n;
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic            if_gnt, if_rvalid, if_err;
   logic [DW-1:0]   if_rdata;
   logic            d_req, d_we;
   logic [AW-1:0]   d_addr;
   logic [DW-1:0]   d_wdata;
   logic [DW/8-1:0] d_wstrb;
   logic            d_gnt, d_rvalid, d_err;
   logic [DW-1:0]   d_rdata;
   logic            m_req, m_we;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_wstrb;
   logic            m_gnt, m_rvalid;
   logic [DW-1:0]   m_rdata;
   logic            busy;

   int vec;
   int miss;

   // auto memory model state
   bit          mem_auto;
   int          mem_lat;
   int          pcnt;
   bit          pend;
   logic [31:0] mem_addr;

   mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata), .o_if_err(if_err),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_wstrb(d_wstrb),
      .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
      .o_m_req(m_req), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb),
      .i_m_gnt(m_gnt), .i_m_rvalid(m_rvalid), .i_m_rdata(m_rdata),
      .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // Advance one cycle; sample point is 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (mem_auto) begin
         m_gnt    = 1'b0;
         m_rvalid = 1'b0;
         if (m_req) begin
            m_gnt    = 1'b1;
            mem_addr = m_addr;
            if (mem_lat == 0) begin
               m_rvalid = 1'b1;
               m_rdata  = mem_fn(m_addr);
            end else begin
               pend = 1'b1;
               pcnt = mem_lat;
            end
         end else if (pend) begin
            pcnt = pcnt - 1;
            if (pcnt == 0) begin
               pend     = 1'b0;
               m_rvalid = 1'b1;
               m_rdata  = mem_fn(mem_addr);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [DW*3+AW+DW/4+10:0] all;
      rst_n = 1'b0;
      tick();
      tick();
      all = {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
             m_req, m_we, m_addr, m_wdata, m_wstrb, busy};
      vec++;
      if (all !== '0) begin
         miss++;
         $display("FAIL reset_outputs: got %h expected 0", all);
      end
      rst_n = 1'b1;
      tick();
      vec++;
      if ({if_gnt, d_gnt, m_req, busy} !== 4'b0000) begin
         miss++;
         $display("FAIL reset_idle: got %b expected 0000", {if_gnt, d_gnt, m_req, busy});
      end
   endtask

   task automatic test_fetch();
      if_req  = 1'b1;
      if_addr = 32'h40;
      tick();
      vec++;
      if ({if_gnt, d_gnt, m_req, m_we, busy} !== 5'b10101) begin
         miss++;
         $display("FAIL fetch_gnt: got %b expected 10101", {if_gnt, d_gnt, m_req, m_we, busy});
      end
      vec++;
      if ({m_addr, m_wdata, m_wstrb} !== {32'h40, 32'h0, 4'h0}) begin
         miss++;
         $display("FAIL fetch_fields: got addr %h wdata %h wstrb %h expected 40/0/0", m_addr, m_wdata, m_wstrb);
      end
      if_req   = 1'b0;
      m_gnt    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'h00500093;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      vec++;
      if ({if_rvalid, if_err, d_rvalid, m_req, busy} !== 5'b10000) begin
         miss++;
         $display("FAIL fetch_rsp: got %b expected 10000", {if_rvalid, if_err, d_rvalid, m_req, busy});
      end
      vec++;
      if (if_rdata !== 32'h00500093) begin
         miss++;
         $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata);
      end
      tick();
      vec++;
      if ({if_rvalid, if_gnt} !== 2'b00) begin
         miss++;
         $display("FAIL fetch_pulse: got %b expected 00", {if_rvalid, if_gnt});
      end
   endtask

   task automatic test_write();
      // prior read sets o_d_rdata to a known value
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h200;
      tick();
      vec++;
      if ({d_gnt, if_gnt, m_we} !== 3'b100) begin
         miss++;
         $display("FAIL dread_gnt: got %b expected 100", {d_gnt, if_gnt, m_we});
      end
      d_req = 1'b0;
      m_gnt = 1'b1;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = 32'h12345678;
      tick();
      m_rvalid = 1'b0;
      vec++;
      if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h12345678}) begin
         miss++;
         $display("FAIL dread_rsp: got %b/%b/%h expected 1/0/12345678", d_rvalid, d_err, d_rdata);
      end
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h100;
      d_wdata = 32'hDEADBEEF;
      d_wstrb = 4'h3;
      tick();
      vec++;
      if ({d_gnt, m_req, m_we, m_addr, m_wdata, m_wstrb} !== {3'b111, 32'h100, 32'hDEADBEEF, 4'h3}) begin
         miss++;
         $display("FAIL write_fields: got gnt %b req %b we %b addr %h wdata %h wstrb %h", d_gnt, m_req, m_we, m_addr, m_wdata, m_wstrb);
      end
      d_req    = 1'b0;
      d_we     = 1'b0;
      m_gnt    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'hFFFFFFFF;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      vec++;
      if ({d_rvalid, d_err, if_rvalid} !== 3'b100) begin
         miss++;
         $display("FAIL write_ack: got %b expected 100", {d_rvalid, d_err, if_rvalid});
      end
      vec++;
      if (d_rdata !== 32'h12345678) begin
         miss++;
         $display("FAIL write_rdata_kept: got %h expected 12345678", d_rdata);
      end
   endtask

   task automatic test_timeout();
      if_req  = 1'b1;
      if_addr = 32'h300;
      tick();
      vec++;
      if ({if_gnt, m_addr} !== {1'b1, 32'h300}) begin
         miss++;
         $display("FAIL to_gnt: got %b/%h expected 1/300", if_gnt, m_addr);
      end
      if_req = 1'b0;
      m_gnt  = 1'b1;
      tick();
      m_gnt = 1'b0;
      // cycles k .. k+4 of WAIT: no response yet
      for (int i = 0; i < 5; i++) begin
         vec++;
         if ({if_rvalid, busy} !== 2'b01) begin
            miss++;
            $display("FAIL to_wait_%0d: got %b expected 01", i, {if_rvalid, busy});
         end
         tick();
      end
      vec++;
      if ({if_rvalid, if_err, d_rvalid, busy} !== 4'b1100) begin
         miss++;
         $display("FAIL to_err: got %b expected 1100", {if_rvalid, if_err, d_rvalid, busy});
      end
      vec++;
      if (if_rdata !== 32'h00500093) begin
         miss++;
         $display("FAIL to_rdata_kept: got %h expected 00500093", if_rdata);
      end
      if_req  = 1'b1;
      if_addr = 32'h44;
      tick();
      vec++;
      if ({if_gnt, if_err, m_addr} !== {2'b10, 32'h44}) begin
         miss++;
         $display("FAIL to_next_gnt: got %b/%b/%h expected 1/0/44", if_gnt, if_err, m_addr);
      end
      if_req   = 1'b0;
      m_gnt    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'h11;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      vec++;
      if ({if_rvalid, if_err, if_rdata} !== {2'b10, 32'h11}) begin
         miss++;
         $display("FAIL to_next_rsp: got %b/%b/%h expected 1/0/11", if_rvalid, if_err, if_rdata);
      end
   endtask

   task automatic test_gnt_stall();
      // last owner is fetch, so data wins the tie
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h400;
      if_req  = 1'b1;
      if_addr = 32'h500;
      tick();
      vec++;
      if ({d_gnt, if_gnt, m_we, m_addr} !== {3'b100, 32'h400}) begin
         miss++;
         $display("FAIL stall_gnt: got %b%b%b/%h expected 100/400", d_gnt, if_gnt, m_we, m_addr);
      end
      d_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         vec++;
         if ({m_req, busy, if_gnt, d_rvalid, if_rvalid, d_err, m_addr} !== {6'b110000, 32'h400}) begin
            miss++;
            $display("FAIL stall_hold_%0d: got %b%b%b%b%b%b/%h expected 110000/400", i, m_req, busy, if_gnt, d_rvalid, if_rvalid, d_err, m_addr);
         end
      end
      m_gnt    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'hCAFE0001;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      vec++;
      if ({d_rvalid, d_rdata} !== {1'b1, 32'hCAFE0001}) begin
         miss++;
         $display("FAIL stall_rsp: got %b/%h expected 1/cafe0001", d_rvalid, d_rdata);
      end
      tick();
      vec++;
      if ({if_gnt, d_gnt, m_addr} !== {2'b10, 32'h500}) begin
         miss++;
         $display("FAIL stall_second_gnt: got %b%b/%h expected 10/500", if_gnt, d_gnt, m_addr);
      end
      if_req   = 1'b0;
      m_gnt    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'hBEEF;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      vec++;
      if ({if_rvalid, if_rdata} !== {1'b1, 32'hBEEF}) begin
         miss++;
         $display("FAIL stall_second_rsp: got %b/%h expected 1/beef", if_rvalid, if_rdata);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW*3+AW+DW/4+10:0] all;
      d_req  = 1'b1;
      d_addr = 32'h600;
      tick();
      d_req = 1'b0;
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      vec++;
      if ({busy, d_gnt} !== 2'b10) begin
         miss++;
         $display("FAIL rmid_wait: got %b expected 10", {busy, d_gnt});
      end
      rst_n = 1'b0;
      #1;
      all = {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
             m_req, m_we, m_addr, m_wdata, m_wstrb, busy};
      vec++;
      if (all !== '0) begin
         miss++;
         $display("FAIL rmid_async: got %h expected 0", all);
      end
      tick();
      rst_n    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'h77;
      tick();
      m_rvalid = 1'b0;
      vec++;
      if ({if_rvalid, d_rvalid, busy, m_req, d_rdata} !== {4'b0000, 32'h0}) begin
         miss++;
         $display("FAIL rmid_late_rsp: got %b%b%b%b/%h expected 0000/0", if_rvalid, d_rvalid, busy, m_req, d_rdata);
      end
      d_req   = 1'b1;
      d_addr  = 32'h604;
      if_req  = 1'b1;
      if_addr = 32'h700;
      tick();
      vec++;
      if ({d_gnt, if_gnt, m_addr} !== {2'b10, 32'h604}) begin
         miss++;
         $display("FAIL rmid_tie: got %b%b/%h expected 10/604", d_gnt, if_gnt, m_addr);
      end
      d_req    = 1'b0;
      if_req   = 1'b0;
      m_gnt    = 1'b1;
      m_rvalid = 1'b1;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      logic        exp_own  [4];
      logic [31:0] exp_addr [4];
      int ng;
      int nr;
      int cyc;
      exp_own  = '{1'b1, 1'b0, 1'b1, 1'b0};
      exp_addr = '{32'h800, 32'h0, 32'h804, 32'h4};
      ng  = 0;
      nr  = 0;
      cyc = 0;
      rst_n = 1'b0;
      tick();
      rst_n    = 1'b1;
      mem_auto = 1'b1;
      mem_lat  = 2;
      pend     = 1'b0;
      if_req   = 1'b1;
      if_addr  = 32'h0;
      d_req    = 1'b1;
      d_we     = 1'b0;
      d_addr   = 32'h800;
      while (nr < 4 && cyc < 80) begin
         tick();
         cyc++;
         if (if_gnt && d_gnt) begin
            vec++;
            miss++;
            $display("FAIL rr_dual_gnt: both grants high at cycle %0d", cyc);
         end
         if ((if_gnt || d_gnt) && ng < 4) begin
            vec++;
            if ({d_gnt, m_addr} !== {exp_own[ng], exp_addr[ng]}) begin
               miss++;
               $display("FAIL rr_gnt_%0d: got owner %b addr %h expected %b/%h", ng, d_gnt, m_addr, exp_own[ng], exp_addr[ng]);
            end
         end
         if (if_gnt) if_addr = if_addr + 32'h4;
         if (d_gnt)  d_addr  = d_addr + 32'h4;
         if (if_gnt || d_gnt) ng++;
         if ((if_rvalid || d_rvalid) && nr < 4) begin
            vec++;
            if ({d_rvalid, if_rvalid, (d_rvalid ? d_rdata : if_rdata)} !==
                {exp_own[nr], ~exp_own[nr], mem_fn(exp_addr[nr])}) begin
               miss++;
               $display("FAIL rr_rsp_%0d: got d %b if %b data %h expected owner %b data %h", nr, d_rvalid, if_rvalid, (d_rvalid ? d_rdata : if_rdata), exp_own[nr], mem_fn(exp_addr[nr]));
            end
            nr++;
         end
      end
      vec++;
      if (nr < 4) begin
         miss++;
         $display("FAIL rr_budget: got %0d responses expected 4", nr);
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      mem_auto = 1'b0;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
   endtask

   initial begin
      vec      = 0;
      miss     = 0;
      mem_auto = 1'b0;
      mem_lat  = 0;
      pcnt     = 0;
      pend     = 1'b0;
      mem_addr = '0;
      rst_n    = 1'b0;
      if_req   = 1'b0;
      if_addr  = '0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_addr   = '0;
      d_wdata  = '0;
      d_wstrb  = '0;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = '0;

      test_reset();
      test_fetch();
      test_write();
      test_timeout();
      test_gnt_stall();
      test_reset_mid();
      test_round_robin();

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
